// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receiving end of a multiplexed 4-digit seven-segment bus. Samples the
//   active-low seg/an lines on sample_en strobes and rebuilds the mm:ss value
//   that was scanned out. It checks glyph validity, one-hot anode selects and
//   scan order.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   sample_en   sample strobe, one per scan step (may be held high)
//   seg[6:0]    segment lines, active low, bit6=g .. bit0=a
//   an[3:0]     anode lines, active low: 0=min tens, 1=min ones,
//               2=sec tens, 3=sec ones
//   minutes     last complete minutes value (0-59)
//   seconds     last complete seconds value (0-59)
//   frame_valid one-cycle pulse when minutes/seconds update
//   blank       level, last sampled digit was the all-off glyph
//   err         one-cycle pulse on any protocol or glyph error
//   stale       level, no anode seen for STALE_LIMIT strobes
module seg_scan_decoder #(
  parameter int STALE_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       frame_valid,
  output logic       blank,
  output logic       err,
  output logic       stale
);

  localparam int CW = $clog2(STALE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALE_LIMIT);

  // EXPk means digit position k is the next one expected in the frame.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP3 = 2'd3
  } state_t;

  // Active-low glyph to BCD digit; returns {valid, digit}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'b1000000: decode_glyph = {1'b1, 4'd0};
      7'b1111001: decode_glyph = {1'b1, 4'd1};
      7'b0100100: decode_glyph = {1'b1, 4'd2};
      7'b0110000: decode_glyph = {1'b1, 4'd3};
      7'b0011001: decode_glyph = {1'b1, 4'd4};
      7'b0010010: decode_glyph = {1'b1, 4'd5};
      7'b0000010: decode_glyph = {1'b1, 4'd6};
      7'b1111000: decode_glyph = {1'b1, 4'd7};
      7'b0000000: decode_glyph = {1'b1, 4'd8};
      7'b0011000: decode_glyph = {1'b1, 4'd9};
      default:    decode_glyph = {1'b0, 4'd0};
    endcase
  endfunction

  // tens*10 + units; tens is range-checked to <=5 before use, so 6 bits suffice.
  function automatic logic [5:0] tens_units(input logic [3:0] t, input logic [3:0] u);
    tens_units = {t[2:0], 3'b000} + {1'b0, t, 1'b0} + {2'b00, u};
  endfunction

  state_t        state_r, state_n;
  logic [3:0]    mt_r, mo_r, st_r;
  logic [3:0]    mt_n, mo_n, st_n;
  logic [5:0]    min_r, sec_r, min_n, sec_n;
  logic          fv_r, err_r, blank_r, stale_r;
  logic          fv_n, err_n, blank_n, stale_n;
  logic [CW-1:0] cnt_r, cnt_n;

  logic [4:0]    glyph_s;
  logic          glyph_valid_s, glyph_blank_s;
  logic [3:0]    digit_s;
  logic [1:0]    pos_s;
  logic          an_none_s, an_multi_s;

  assign glyph_s       = decode_glyph(seg);
  assign glyph_valid_s = glyph_s[4];
  assign digit_s       = glyph_s[3:0];
  assign glyph_blank_s = (seg == 7'b1111111);

  // Classify the anode bus into a digit position, NONE or MULTI.
  always_comb begin
    pos_s      = 2'd0;
    an_none_s  = 1'b0;
    an_multi_s = 1'b0;
    case (an)
      4'b1110: pos_s = 2'd0;
      4'b1101: pos_s = 2'd1;
      4'b1011: pos_s = 2'd2;
      4'b0111: pos_s = 2'd3;
      4'b1111: an_none_s = 1'b1;
      default: an_multi_s = 1'b1;
    endcase
  end

  // Next-state, digit capture, frame assembly and flag logic.
  always_comb begin
    state_n = state_r;
    mt_n    = mt_r;
    mo_n    = mo_r;
    st_n    = st_r;
    min_n   = min_r;
    sec_n   = sec_r;
    blank_n = blank_r;
    stale_n = stale_r;
    cnt_n   = cnt_r;
    fv_n    = 1'b0;
    err_n   = 1'b0;
    if (sample_en) begin
      if (an_none_s) begin
        // No digit driven: only the stale watchdog moves.
        if (cnt_r != CNT_MAX) begin
          cnt_n = cnt_r + CNT_ONE;
        end else begin
          cnt_n = cnt_r;
        end
        stale_n = (cnt_n == CNT_MAX);
      end else begin
        cnt_n   = '0;
        stale_n = 1'b0;
        if (an_multi_s || (!glyph_valid_s && !glyph_blank_s)) begin
          err_n   = 1'b1;
          state_n = HUNT;
        end else if (glyph_blank_s) begin
          blank_n = 1'b1;
          state_n = HUNT;
        end else begin
          blank_n = 1'b0;
          case (state_r)
            HUNT: begin
              // Mid-frame join: anything but position 0 is silently skipped.
              if (pos_s == 2'd0) begin
                mt_n    = digit_s;
                state_n = EXP1;
              end else begin
                state_n = HUNT;
              end
            end
            EXP1: begin
              case (pos_s)
                2'd0:    mt_n = digit_s;
                2'd1:    begin mo_n = digit_s; state_n = EXP2; end
                default: begin err_n = 1'b1; state_n = HUNT; end
              endcase
            end
            EXP2: begin
              case (pos_s)
                2'd0:    begin err_n = 1'b1; mt_n = digit_s; state_n = EXP1; end
                2'd1:    mo_n = digit_s;
                2'd2:    begin st_n = digit_s; state_n = EXP3; end
                default: begin err_n = 1'b1; state_n = HUNT; end
              endcase
            end
            EXP3: begin
              case (pos_s)
                2'd0:    begin err_n = 1'b1; mt_n = digit_s; state_n = EXP1; end
                2'd2:    st_n = digit_s;
                2'd3: begin
                  // Seconds ones arrives live; the frame closes on this sample.
                  state_n = HUNT;
                  if ((mt_r > 4'd5) || (st_r > 4'd5)) begin
                    err_n = 1'b1;
                  end else begin
                    min_n = tens_units(mt_r, mo_r);
                    sec_n = tens_units(st_r, digit_s);
                    fv_n  = 1'b1;
                  end
                end
                default: begin err_n = 1'b1; state_n = HUNT; end
              endcase
            end
            default: state_n = HUNT;
          endcase
        end
      end
    end else begin
      state_n = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
      mt_r    <= 4'd0;
      mo_r    <= 4'd0;
      st_r    <= 4'd0;
      min_r   <= 6'd0;
      sec_r   <= 6'd0;
      fv_r    <= 1'b0;
      err_r   <= 1'b0;
      blank_r <= 1'b0;
      stale_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      mt_r    <= mt_n;
      mo_r    <= mo_n;
      st_r    <= st_n;
      min_r   <= min_n;
      sec_r   <= sec_n;
      fv_r    <= fv_n;
      err_r   <= err_n;
      blank_r <= blank_n;
      stale_r <= stale_n;
      cnt_r   <= cnt_n;
    end
  end

  assign minutes     = min_r;
  assign seconds     = sec_r;
  assign frame_valid = fv_r;
  assign err         = err_r;
  assign blank       = blank_r;
  assign stale       = stale_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: a vector table of scan steps with the
// outputs expected after each step, plus hand-written sequences for
// continuous sampling and reset mid-frame. Expected records go through a
// queue and are compared after the DUT clocks the sample.
module tb_seg_scan_decoder;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0011000;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GX = 7'b0101010;

  localparam logic [3:0] P0 = 4'b1110;
  localparam logic [3:0] P1 = 4'b1101;
  localparam logic [3:0] P2 = 4'b1011;
  localparam logic [3:0] P3 = 4'b0111;
  localparam logic [3:0] PN = 4'b1111;
  localparam logic [3:0] PM = 4'b1100;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic [5:0] minutes, seconds;
  logic       frame_valid, blank, err, stale;

  seg_scan_decoder #(.STALE_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .seg(seg), .an(an),
    .minutes(minutes), .seconds(seconds), .frame_valid(frame_valid),
    .blank(blank), .err(err), .stale(stale)
  );

  always #5 clk = ~clk;

  // expected record layout: {frame_valid, err, blank, stale, minutes, seconds}
  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs [0:127];
  int          n_vecs = 0;
  logic [15:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  function automatic logic [15:0] mk(input logic fv, input logic e, input logic b,
                                     input logic s, input logic [5:0] mn, input logic [5:0] sc);
    mk = {fv, e, b, s, mn, sc};
  endfunction

  task automatic add(input logic [3:0] a, input logic [6:0] s, input logic [15:0] e,
                     input string name);
    vecs[n_vecs].an   = a;
    vecs[n_vecs].seg  = s;
    vecs[n_vecs].exp  = e;
    vecs[n_vecs].name = name;
    n_vecs++;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] e);
    total_cnt++;
    if (act === e) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got fv=%b err=%b blank=%b stale=%b min=%0d sec=%0d, expected fv=%b err=%b blank=%b stale=%b min=%0d sec=%0d",
               name, act[15], act[14], act[13], act[12], act[11:6], act[5:0],
               e[15], e[14], e[13], e[12], e[11:6], e[5:0]);
    end
  endtask

  function automatic logic [15:0] observed();
    observed = {frame_valid, err, blank, stale, minutes, seconds};
  endfunction

  // One sample strobe, then idle clocks; the first idle clock must show both pulses low.
  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic [15:0] e,
                      input int idle, input string name);
    logic [15:0] want;
    an = a;
    seg = s;
    sample_en = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(name, observed(), want);
    sample_en = 1'b0;
    an = PN;
    seg = GB;
    for (int k = 0; k < idle; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        check({name, "_pulse_end"}, {frame_valid, err, 14'd0}, {2'b00, 14'd0});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_en = 1'b0;
    an = PN;
    seg = GB;

    // clean 12:34
    add(P0, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0), "clean_p0");
    add(P1, G2, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0), "clean_p1");
    add(P2, G3, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0), "clean_p2");
    add(P3, G4, mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "clean_p3");
    // mid-frame join, then 59:59
    add(P2, G5, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "join_p2");
    add(P3, G9, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "join_p3");
    add(P0, G5, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "f59_p0");
    add(P1, G9, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "f59_p1");
    add(P2, G5, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "f59_p2");
    add(P3, G9, mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd59, 6'd59), "f59_p3");
    // out of order, then 00:07
    add(P0, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd59, 6'd59), "ooo_p0");
    add(P2, G3, mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd59, 6'd59), "ooo_p2_err");
    add(P0, G0, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd59, 6'd59), "f07_p0");
    add(P1, G0, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd59, 6'd59), "f07_p1");
    add(P2, G0, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd59, 6'd59), "f07_p2");
    add(P3, G7, mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd7), "f07_p3");
    // blank glyph, then invalid glyph
    add(P1, GB, mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd7), "blank_p1");
    add(P0, GX, mk(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 6'd7), "invalid_p0");
    // repeated digits overwrite: result 12:45
    add(P0, G2, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd7), "rep_p0a");
    add(P0, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd7), "rep_p0b");
    add(P1, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd7), "rep_p1a");
    add(P1, G2, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd7), "rep_p1b");
    add(P2, G4, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd7), "rep_p2");
    add(P3, G5, mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd12, 6'd45), "rep_p3");
    // position 0 out of order restarts the frame: result 34:56
    add(P0, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd45), "rst0_p0");
    add(P1, G2, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd45), "rst0_p1");
    add(P0, G3, mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd12, 6'd45), "rst0_p0_err");
    add(P1, G4, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd45), "rst0_p1b");
    add(P2, G5, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd45), "rst0_p2");
    add(P3, G6, mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "rst0_p3");
    // tens range errors and a multi-anode select
    add(P0, G7, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "mt7_p0");
    add(P1, G0, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "mt7_p1");
    add(P2, G0, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "mt7_p2");
    add(P3, G0, mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd34, 6'd56), "mt7_p3_err");
    add(P0, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "st6_p0");
    add(P1, G0, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "st6_p1");
    add(P2, G6, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "st6_p2");
    add(P3, G0, mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd34, 6'd56), "st6_p3_err");
    add(PM, G1, mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd34, 6'd56), "multi_err");
    // an idle gap inside a frame keeps the collect state
    add(P0, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "gap_p0");
    add(PN, G8, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "gap_none");
    add(P1, G2, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "gap_p1");
    add(P2, G3, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 6'd56), "gap_p2");
    add(P3, G4, mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "gap_p3");
    // stale watchdog: asserts on the 16th empty strobe and saturates
    for (int i = 0; i < 17; i++) begin
      add(PN, G8, mk(1'b0, 1'b0, 1'b0, (i >= 15), 6'd12, 6'd34), $sformatf("stale_%0d", i + 1));
    end
    add(P1, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), "stale_clear");

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observed(), 16'd0);
    rst = 1'b0;

    for (int i = 0; i < n_vecs; i++) begin
      step(vecs[i].an, vecs[i].seg, vecs[i].exp, 3, vecs[i].name);
    end

    // sample_en held high: each digit seen three times, result 23:45
    for (int r = 0; r < 3; r++) step(P0, G2, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), 0, "cont_p0");
    for (int r = 0; r < 3; r++) step(P1, G3, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), 0, "cont_p1");
    for (int r = 0; r < 3; r++) step(P2, G4, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 6'd34), 0, "cont_p2");
    step(P3, G5, mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd23, 6'd45), 0, "cont_p3a");
    step(P3, G5, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd23, 6'd45), 3, "cont_p3b");

    // reset mid-frame discards the partial digits
    step(P0, G1, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd23, 6'd45), 3, "mid_rst_p0");
    step(P1, G2, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd23, 6'd45), 3, "mid_rst_p1");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_outputs", observed(), 16'd0);
    rst = 1'b0;
    step(P2, G3, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0), 3, "mid_rst_p2");
    step(P3, G4, mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0), 3, "mid_rst_p3");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 4-digit seven-segment interface: samples the active-low seg/an bus and rebuilds the minutes/seconds values that were scanned out.
- Used in loopback self-check and bench scoreboarding, and as the input stage when a second board reads another board's display bus.
- Checks glyph validity, one-hot anode selects and scan order.
- Emits a registered frame with a one-cycle strobe, plus error and stale flags.

Parameters:
- STALE_LIMIT, 16, number of consecutive sample_en strobes with no anode active before stale asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- sample_en  in  1  sample strobe; bus is sampled only on clk edges where sample_en=1 (one per scan step).
- seg  in  7  segment lines, active low, bit6=g .. bit0=a.
- an  in  4  anode lines, active low; an[0]=minutes tens, an[1]=minutes ones, an[2]=seconds tens, an[3]=seconds ones.
- minutes  out  6  last complete minutes value, 0-59.
- seconds  out  6  last complete seconds value, 0-59.
- frame_valid  out  1  one-cycle pulse when minutes/seconds update.
- blank  out  1  level; last sampled digit was all-off glyph 7'b1111111.
- err  out  1  one-cycle pulse on any protocol/glyph error.
- stale  out  1  level; no anode seen for STALE_LIMIT strobes.

Behaviour:
- Reset (rst=1 at clk edge): minutes=0, seconds=0, frame_valid=0, blank=0, err=0, stale=0, state=HUNT, digit regs=0, stale counter=0.
- Glyph decode is active-low: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9.
- 1111111 is BLANK. Any other pattern is INVALID.
- Anode classes: exactly one bit low gives digit position 0-3. 4'b1111 is NONE. Anything else is MULTI.
- All logic is evaluated only when sample_en=1. Otherwise all registers hold, and frame_valid/err are 0.
- NONE:
  - stale counter increments, saturating at STALE_LIMIT.
  - stale=1 when counter==STALE_LIMIT.
  - state is unchanged.
- Any anode other than NONE clears the stale counter and stale in the same cycle.
- MULTI, or INVALID glyph: err pulse, state goes to HUNT, partial digits are discarded.
- BLANK glyph: blank=1, state goes to HUNT, no err. A non-blank valid glyph sets blank=0.
- State HUNT:
  - Waits for position 0 with a valid digit.
  - Position 0 stores mt and goes to COLLECT with expect=1.
  - Positions 1-3 are ignored without err (mid-frame join).
- State COLLECT(expect=k):
  - Position==k-1 (repeat of the previous digit, i.e. sampling faster than scan): overwrite that digit, stay.
  - Position==k: store the digit and set expect=k+1.
  - Position==0 out of order: err pulse, store mt, expect=1 (restart).
  - Any other position: err pulse, go to HUNT.
- Frame completion, when position 3 is stored:
  - Tens range check: mt>5 or st>5 gives err pulse, outputs unchanged, state goes to HUNT.
  - Otherwise minutes=mt*10+mo and seconds=st*10+so, each computed into a 6-bit result (max 59, no overflow).
  - Outputs and frame_valid=1 are registered on the same clk edge as the position-3 sample, so they are visible the cycle after.
  - State returns to HUNT, ready for the next position 0.
- frame_valid and err are never 1 in the same cycle. err has priority, and outputs are not updated on err.
- rst asserted mid-frame aborts the frame. No frame_valid is produced for partial data.
- sample_en held high continuously is legal: repeated digits are handled by the overwrite rule.

Test Plan:
- Clean scan of 12:34 (an 1110/1101/1011/0111 with glyphs 1,2,3,4, sample_en every 4 clks) -> frame_valid pulse one cycle after the 4th sample, minutes=12, seconds=34, err=0.
- Join mid-frame (first samples at positions 2,3, then a full 59:59 scan) -> no err; single frame_valid with minutes=59, seconds=59.
- Out of order (positions 0,2) -> err pulse at the position-2 sample, no frame_valid; next clean 00:07 frame -> minutes=0, seconds=7.
- Glyph 1111111 at position 1, then glyph 0101010 at position 0 -> blank=1 with no err; then err pulse; outputs hold the previous frame.
- Tens range: scan 7,0,0,0 -> err at the 4th sample, minutes/seconds unchanged; an=4'b1100 -> err pulse.
- an=1111 for 16 strobes -> stale=1 on the 16th; next valid anode -> stale=0. rst mid-frame -> all outputs 0 next cycle, no frame_valid.
